uart_tx_core: RTL and testbench



---
 rtl/uart_tx_core.sv | 100 ++++++++++
 tb/tb_uart_tx_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART transmitter driven by a level enable / busy handshake
module uart_tx_core #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam int IW = PAYLOAD_BITS > 1 ? $clog2(PAYLOAD_BITS) : 1;
  localparam int SW = STOP_BITS > 1 ? $clog2(STOP_BITS) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(PAYLOAD_BITS - 1);
  localparam logic [SW-1:0] STP_LAST = SW'(STOP_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [IW-1:0]           bit_q, bit_d;
  logic [SW-1:0]           stp_q, stp_d;
  logic [PAYLOAD_BITS-1:0] shr_q, shr_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    bit_end;
  assign bit_end      = cyc_q == CYC_LAST;
  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  // Next state: txd/busy are computed one cycle ahead so both leave the core straight from flops
  always_comb begin
    state_d = state_q;
    cyc_d   = (state_q == IDLE || bit_end) ? '0 : cyc_q + 1'b1;
    bit_d   = bit_q;
    stp_d   = stp_q;
    shr_d   = shr_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (uart_tx_en) begin
        state_d = START;
        shr_d   = uart_tx_data;
        txd_d   = 1'b0;
        busy_d  = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        txd_d   = shr_q[0];
        shr_d   = shr_q >> 1;
      end
      DATA: if (bit_end) begin
        if (bit_q == BIT_LAST) begin
          state_d = STOP;
          bit_d   = '0;
          stp_d   = '0;
          txd_d   = 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
          txd_d = shr_q[0];
          shr_d = shr_q >> 1;
        end
      end
      STOP: if (bit_end) begin
        if (stp_q == STP_LAST) begin
          state_d = IDLE;
          stp_d   = '0;
          busy_d  = 1'b0;
        end else begin
          stp_d = stp_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; reset forces the line high immediately, aborting any frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      stp_q   <= '0;
      shr_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      stp_q   <= stp_d;
      shr_q   <= shr_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: random and directed frames checked by a line-level model and a decoding receiver
module tb_uart_tx_core;
  localparam int CPB   = 1_000_000 / 115_200;
  localparam int FRAME = 10 * CPB;
  typedef struct {logic [7:0] b; int t;} exp_t;
  logic clk = 0, resetn = 0, uart_tx_en = 0;
  logic [7:0] uart_tx_data = 0;
  logic uart_txd, uart_tx_busy;
  exp_t q[$];
  int starts[$];
  int cyc = 0, m_start = 0, errors = 0, checks = 0, rx_cnt = 0, exp_frames = 0;
  int rx_t0 = 0, low_cnt = 0, last_low = 0, busy_cnt = 0, last_busy = 0;
  logic m_active = 0, rx_on = 0;
  logic [7:0] m_byte = 0, rx_sh = 0;
  int k, rk;
  logic eb, et;

  uart_tx_core #(.BIT_RATE(115_200), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .resetn(resetn), .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Line level of an 8N1 frame k cycles after its acceptance edge
  function automatic logic wave_bit(int kk, logic [7:0] b);
    int i = kk / CPB;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    return 1'b1;
  endfunction

  assign k  = cyc - m_start;
  assign eb = m_active && k >= 0 && k < FRAME;
  assign et = eb ? wave_bit(k, m_byte) : 1'b1;
  assign rk = cyc - rx_t0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an idle transmitter accepts enable; it is idle again FRAME+1 edges later
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_active <= 0;
      q.delete();
    end else if (uart_tx_en && (!m_active || cyc + 1 > m_start + FRAME)) begin
      m_active <= 1;
      m_start  <= cyc + 1;
      m_byte   <= uart_tx_data;
      q.push_back('{uart_tx_data, cyc + 1});
    end
  end

  // Cycle-exact line and busy comparison against the model
  always @(negedge clk) begin
    chk("busy", uart_tx_busy === eb, uart_tx_busy, eb);
    chk("txd", uart_txd === et, uart_txd, et);
  end

  // Run-length monitors for busy-high and line-low stretches
  always @(negedge clk) begin
    if (!uart_txd) low_cnt <= low_cnt + 1;
    else begin
      if (low_cnt != 0) last_low <= low_cnt;
      low_cnt <= 0;
    end
    if (uart_tx_busy) busy_cnt <= busy_cnt + 1;
    else begin
      if (busy_cnt != 0) last_busy <= busy_cnt;
      busy_cnt <= 0;
    end
  end

  task automatic score(input logic [7:0] b, input int t0, input logic stop);
    exp_t e;
    chk("stop_bit", stop === 1'b1, stop, 1);
    if (q.size() == 0) chk("spurious_frame", 0, b, 0);
    else begin
      e = q.pop_front();
      chk("rx_byte", b === e.b, b, e.b);
      chk("rx_start_cycle", t0 == e.t, t0, e.t);
    end
    rx_cnt++;
    starts.push_back(t0);
  endtask

  // Receiver: detects the start edge, samples each bit mid-way and scores at the stop bit
  always @(negedge clk) begin
    if (!resetn) rx_on <= 0;
    else if (!rx_on) begin
      if (!uart_txd) begin
        rx_on <= 1;
        rx_t0 <= cyc;
      end
    end else if (rk % CPB == CPB / 2) begin
      if (rk / CPB == 0) chk("start_bit", uart_txd === 1'b0, uart_txd, 0);
      else if (rk / CPB <= 8) rx_sh[rk/CPB-1] <= uart_txd;
      else begin
        rx_on <= 0;
        score(rx_sh, rx_t0, uart_txd);
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    uart_tx_data = b;
    uart_tx_en   = 1;
    @(negedge clk);
    uart_tx_en = 0;
    exp_frames++;
  endtask

  task automatic wait_fall();
    bit seen = 0, ok = 0;
    for (int n = 0; n < 3 * FRAME && !ok; n++) begin
      @(negedge clk);
      if (uart_tx_busy) seen = 1;
      else if (seen) ok = 1;
    end
    chk("busy_fall_seen", ok, ok, 1);
  endtask

  initial begin
    int s0;
    gap(3);
    chk("reset_txd", uart_txd === 1'b1, uart_txd, 1);
    chk("reset_busy", uart_tx_busy === 1'b0, uart_tx_busy, 0);
    resetn = 1;
    gap(2);
    send(8'h96);
    gap(3 * CPB);
    #2 resetn = 0;
    #1;
    chk("async_rst_txd", uart_txd === 1'b1, uart_txd, 1);
    chk("async_rst_busy", uart_tx_busy === 1'b0, uart_tx_busy, 0);
    exp_frames--;
    gap(2);
    resetn = 1;
    gap(FRAME + CPB);
    chk("no_spurious_after_rst", rx_cnt == 0, rx_cnt, 0);
    resetn = 0;
    uart_tx_data = 8'h81;
    uart_tx_en = 1;
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    uart_tx_en = 0;
    exp_frames++;
    gap(FRAME + 5);
    chk("first_edge_accept", rx_cnt == exp_frames, rx_cnt, exp_frames);
    send(8'hA5);
    gap(FRAME + 5);
    chk("a5_busy_len", last_busy == FRAME, last_busy, FRAME);
    chk("a5_frames", rx_cnt == exp_frames, rx_cnt, exp_frames);
    send(8'h00);
    gap(FRAME + 5);
    chk("zero_low_len", last_low == 9 * CPB, last_low, 9 * CPB);
    send(8'hFF);
    gap(FRAME + 5);
    chk("ff_low_len", last_low == CPB, last_low, CPB);
    send(8'h3C);
    gap(3 * CPB);
    uart_tx_data = 8'hC3;
    uart_tx_en = 1;
    @(negedge clk);
    uart_tx_en = 0;
    gap(FRAME);
    chk("busy_ignore_frames", rx_cnt == exp_frames, rx_cnt, exp_frames);
    send(8'h5A);
    gap(FRAME + 5);
    chk("5a_frames", rx_cnt == exp_frames, rx_cnt, exp_frames);
    s0 = starts.size();
    uart_tx_data = 8'($urandom);
    uart_tx_en = 1;
    for (int i = 0; i < 50; i++) begin
      wait_fall();
      exp_frames++;
      if (i < 49) uart_tx_data = 8'($urandom);
      else uart_tx_en = 0;
    end
    gap(5);
    chk("b2b_frames", starts.size() - s0 == 50, starts.size() - s0, 50);
    for (int i = s0 + 1; i < starts.size(); i++)
      chk("b2b_gap", starts[i] - starts[i-1] == FRAME + 1, starts[i] - starts[i-1], FRAME + 1);
    gap(FRAME);
    chk("queue_drained", q.size() == 0, q.size(), 0);
    chk("total_frames", rx_cnt == exp_frames, rx_cnt, exp_frames);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
